hpd_decim: RTL
==============

Name: hpd_decim

Overview:
- High-pass decomposition (analysis) filter for the wavelet front end.
- Counterpart to the high-pass reconstruction filter: it filters the 16-bit ECG sample stream with a 4-tap db2 high-pass decomposition FIR and decimates by 2, producing detail coefficients.
- Sits between the ECG sample source and the detail-coefficient path feeding the LSTM feature extractor.
- Two-stage registered pipeline, advanced only on clk_enable.

Parameters:
- C0, -7913, tap 0 coefficient (newest sample), signed Q2.14
- C1, 13705, tap 1 coefficient, signed Q2.14
- C2, -3672, tap 2 coefficient, signed Q2.14
- C3, -2120, tap 3 coefficient (oldest sample), signed Q2.14

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset; all state clears while reset=0
- clk_enable  input  1  global advance; every register holds when 0
- in  input  16  signed input sample
- in_valid  input  1  sample strobe; sample accepted on a rising edge with clk_enable=1 and in_valid=1
- out  output  16  signed detail coefficient
- out_valid  output  1  out holds a new coefficient; consumer qualifies with clk_enable

Behaviour:
- Reset values (reset=0, immediate, asynchronous): out=0, out_valid=0, delay line x0..x3=0, product registers=0, pipeline valid bits=0, phase=0.
- Accept:
  - On acceptance, shift the delay line: x3<=x2, x2<=x1, x1<=x0, x0<=in.
  - Toggle phase.
  - If phase was 1 before the toggle (2nd, 4th, 6th... accepted sample), set launch valid v1 for the next stage.
  - Odd samples only shift the line.
- Stage 1 (on edge with clk_enable=1):
  - p_k <= Ck*xk, 32-bit signed, k=0..3.
  - pv <= launch.
- Stage 2 (on edge with clk_enable=1):
  - s = p0+p1+p2+p3, 34-bit signed.
  - r = (s + 8192) >>> 14 (round half up, arithmetic shift).
  - Saturate r to [-32768, 32767], then out <= r.
  - out_valid <= pv.
- Latency: out_valid=1 two enabled edges after the edge accepting the even sample. One coefficient per two accepted samples.
- out holds its last value between coefficients. out_valid is 1 for exactly one enabled cycle per coefficient.
- Stall (clk_enable=0): all registers, including out and out_valid, hold. in_valid is ignored.
- in_valid=0 with clk_enable=1: no shift, no phase change; the pipeline still drains.
- Back-to-back samples every enabled cycle: sustained at full rate, no backpressure, no drops.
- Startup: the delay line starts at zero, so the first output uses zero history (no warm-up suppression).
- Reset mid-operation: all in-flight results are discarded, phase returns to 0, and the next accepted sample is treated as sample 1.
- Overflow: only via saturation; no wrap-around is permitted at any stage.

Test Plan:
- Impulse, odd position: reset, then accept 16384, then zeros -> outputs 13705, -2120, 0, 0...
- Impulse, even position: accept 0, 16384, then zeros -> outputs -7913, -3672, 0...
- DC input: constant 1000 -> first output 354, all later outputs 0 (coefficient sum is 0).
- Saturation:
  - Accept 32767, -32768, 32767, -32768 -> 2nd output 32767.
  - Accept -32768, 32767, -32768, 32767 -> 2nd output -32768.
- Stall and gap: impulse test with clk_enable low for 3 cycles between stages, and with in_valid gaps -> identical output sequence; out_valid pulses only on enabled cycles; out is stable during the stall.
- Mid-stream reset:
  - Assert reset=0 one cycle after an even sample is accepted -> out=0, out_valid=0, no stale pulse.
  - After release, accept 16384 then 0 -> output 13705.

Source files
------------

// File: rtl/hpd_decim.sv
// db2 high-pass analysis FIR with decimation by 2; emits one detail coefficient
// for every two accepted 16-bit ECG samples through a two-stage pipeline.
module hpd_decim #(
  parameter logic signed [15:0] C0 = -16'sd7913,
  parameter logic signed [15:0] C1 = 16'sd13705,
  parameter logic signed [15:0] C2 = -16'sd3672,
  parameter logic signed [15:0] C3 = -16'sd2120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic signed [15:0] in,
  input  logic               in_valid,
  output logic signed [15:0] out,
  output logic               out_valid
);

  logic signed [15:0] x0, x1, x2, x3;
  logic               phase;
  logic               v1;
  logic signed [31:0] p0, p1, p2, p3;
  logic               pv;
  logic signed [33:0] sum;
  logic signed [33:0] rnd;
  logic signed [15:0] sat;
  logic               accept;

  assign accept = clk_enable & in_valid;

  // Delay line, decimation phase and launch strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0    <= '0;
      x1    <= '0;
      x2    <= '0;
      x3    <= '0;
      phase <= 1'b0;
      v1    <= 1'b0;
    end else if (clk_enable) begin
      v1 <= in_valid & phase;
      if (accept) begin
        x3    <= x2;
        x2    <= x1;
        x1    <= x0;
        x0    <= in;
        phase <= ~phase;
      end
    end
  end

  // Stage 1: tap products
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      pv <= 1'b0;
    end else if (clk_enable) begin
      p0 <= 32'(C0) * 32'(x0);
      p1 <= 32'(C1) * 32'(x1);
      p2 <= 32'(C2) * 32'(x2);
      p3 <= 32'(C3) * 32'(x3);
      pv <= v1;
    end
  end

  // Stage 2 datapath: sum, round half up, saturate to 16 bits
  always_comb begin
    sum = {{2{p0[31]}}, p0} + {{2{p1[31]}}, p1}
        + {{2{p2[31]}}, p2} + {{2{p3[31]}}, p3};
    rnd = (sum + 34'sd8192) >>> 14;
    sat = rnd[15:0];
    if (rnd > 34'sd32767)
      sat = 16'sh7fff;
    else if (rnd < -34'sd32768)
      sat = 16'sh8000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (clk_enable) begin
      out_valid <= pv;
      if (pv)
        out <= sat;
    end
  end

endmodule
